// File: rtl/lcd_fb_arbiter_pkg.sv
// Shared constants and types for the LCD framebuffer arbiter.
package lcd_pkg;
  localparam int H_ACT   = 800;
  localparam int V_ACT   = 480;
  localparam int FB_SIZE = H_ACT * V_ACT;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 16;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } arb_state_t;
endpackage

// File: rtl/lcd_fb_arbiter_if.sv
// Sync-generator, writer, RAM and panel signals seen by the framebuffer arbiter.
interface lcd_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  logic              pix_tick;
  logic              den;
  logic              frame_st;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              in_frame;
  logic              ovf_err;

  modport slave (
    input  pix_tick, den, frame_st, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, wr_err, mem_addr, mem_wdata, mem_we, pix_data, pix_valid,
           in_frame, ovf_err
  );

  modport master (
    output pix_tick, den, frame_st, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, wr_err, mem_addr, mem_wdata, mem_we, pix_data, pix_valid,
           in_frame, ovf_err
  );
endinterface

// File: rtl/lcd_fb_arbiter_scan.sv
// Scan-out address counter: reload on frame start, wrap at the last pixel,
// sticky overflow on any read after a wrap within the same frame.
module lcd_scan_addr #(
  parameter int          ADDR_W  = 19,
  parameter int unsigned FB_SIZE = 384000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              ovf
);
  logic wrapped;
  logic last;

  assign last = (addr == ADDR_W'(FB_SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      wrapped <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (inc && wrapped) ovf <= 1'b1;
      // frame start beats the increment
      if (load) begin
        addr    <= '0;
        wrapped <= 1'b0;
      end else if (inc) begin
        addr <= last ? '0 : addr + ADDR_W'(1);
        if (last) wrapped <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/lcd_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads win, writer fills free cycles,
// read data is delivered to the panel with a fixed 2-cycle latency.
module lcd_fb_arbiter
  import lcd_pkg::*;
#(
  parameter int H_ACT    = lcd_pkg::H_ACT,
  parameter int V_ACT    = lcd_pkg::V_ACT,
  parameter int ADDR_W   = lcd_pkg::ADDR_W,
  parameter int DATA_W   = lcd_pkg::DATA_W,
  parameter bit BLANK_WR = 1'b0
) (
  input logic              clk,
  input logic              rst,
  lcd_fb_arbiter_if.slave  bus
);
  localparam int unsigned FB     = H_ACT * V_ACT;
  localparam int          STAGES = 2;

  arb_state_t        state, state_nxt;
  logic              scan_rd, blank_ok, grant, addr_bad, ovf;
  logic [ADDR_W-1:0] scan_addr, addr_q, mem_addr_c;
  logic [DATA_W-1:0] wdata_q, mem_wdata_c, pix_q;
  logic              mem_we_c;
  logic [STAGES:1]   vld_pipe;

  assign scan_rd  = (state == ACTIVE) && bus.pix_tick && bus.den;
  assign blank_ok = !BLANK_WR || (state != ACTIVE) || !bus.den;
  // grant is masked by rst so a pending request is never acked during reset
  assign grant    = !rst && bus.wr_req && !scan_rd && blank_ok;
  assign addr_bad = 32'(bus.wr_addr) >= FB;

  lcd_scan_addr #(.ADDR_W(ADDR_W), .FB_SIZE(FB)) u_scan (
    .clk  (clk),
    .rst  (rst),
    .load (bus.frame_st),
    .inc  (scan_rd),
    .addr (scan_addr),
    .ovf  (ovf)
  );

  always_comb begin
    state_nxt   = state;
    mem_addr_c  = addr_q;
    mem_wdata_c = wdata_q;
    mem_we_c    = 1'b0;
    if (state == WAIT_SYNC && bus.frame_st) state_nxt = ACTIVE;
    if (scan_rd) begin
      mem_addr_c = scan_addr;
    end else if (grant) begin
      mem_addr_c  = bus.wr_addr;
      mem_wdata_c = bus.wr_data;
      mem_we_c    = !addr_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_SYNC;
      addr_q   <= '0;
      wdata_q  <= '0;
      vld_pipe <= '0;
      pix_q    <= '0;
    end else begin
      state    <= state_nxt;
      addr_q   <= mem_addr_c;
      wdata_q  <= mem_wdata_c;
      vld_pipe <= {vld_pipe[STAGES-1:1], scan_rd};
      // RAM data is valid the cycle after the address
      if (vld_pipe[STAGES-1]) pix_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.wr_ack    = grant;
  assign bus.wr_err    = grant && addr_bad;
  assign bus.pix_data  = pix_q;
  assign bus.pix_valid = vld_pipe[STAGES];
  assign bus.in_frame  = (state == ACTIVE);
  assign bus.ovf_err   = ovf;
endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Directed bench for lcd_fb_arbiter on a 4x2 frame with a pixel tick every 2nd clock.
module tb_lcd_fb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b1;
  logic        wreq = 1'b0;
  logic [3:0]  waddr = '0;
  logic [15:0] wdat = '0;
  logic [15:0] ram [16];
  int n_chk = 0;
  int n_pass = 0;

  lcd_fb_arbiter_if #(.ADDR_W(4), .DATA_W(16)) bus ();
  lcd_fb_arbiter_if #(.ADDR_W(4), .DATA_W(16)) bus_b ();

  lcd_fb_arbiter #(.H_ACT(4), .V_ACT(2), .ADDR_W(4), .DATA_W(16), .BLANK_WR(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  lcd_fb_arbiter #(.H_ACT(4), .V_ACT(2), .ADDR_W(4), .DATA_W(16), .BLANK_WR(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // synchronous RAM model, reloaded with 0x1000+addr while reset is held
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) ram[k] <= 16'h1000 + 16'(k);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  assign bus_b.mem_rdata = bus.mem_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc(input logic t, input logic d, input logic f);
    @(posedge clk); #1;
    rst = rst_d;
    bus.pix_tick = t;   bus.den = d;   bus.frame_st = f;
    bus.wr_req = wreq;  bus.wr_addr = waddr;  bus.wr_data = wdat;
    bus_b.pix_tick = t; bus_b.den = d; bus_b.frame_st = f;
    bus_b.wr_req = wreq; bus_b.wr_addr = waddr; bus_b.wr_data = wdat;
    @(negedge clk);
  endtask

  function automatic logic [15:0] f2pix(input int a);
    if (a == 5) return 16'hABCD;
    if (a == 6) return 16'h5A5A;
    return 16'h1000 + 16'(a);
  endfunction

  initial begin
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    // reset state
    chk("rst_ack", bus.wr_ack, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_pvld", bus.pix_valid, 0);
    chk("rst_pdata", bus.pix_data, 0);
    chk("rst_inframe", bus.in_frame, 0);
    chk("rst_ovf", bus.ovf_err, 0);

    // frame 1: eight reads from preloaded RAM
    rst_d = 1'b0;
    cyc(0, 1, 1);
    chk("t1_inframe_pre", bus.in_frame, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0);
      chk("t1_addr", bus.mem_addr, i);
      chk("t1_we", bus.mem_we, 0);
      chk("t1_pvld", bus.pix_valid, (i > 0));
      if (i > 0) chk("t1_pdata", bus.pix_data, 16'h1000 + 16'(i - 1));
      cyc(0, 1, 0);
      chk("t1_pvld_off", bus.pix_valid, 0);
      chk("t1_inframe", bus.in_frame, 1);
    end

    // frame 2: writes to 5 and 6 collide with ticks and are deferred
    cyc(0, 1, 1);
    chk("t1_last_pvld", bus.pix_valid, 1);
    chk("t1_last_pdata", bus.pix_data, 16'h1007);
    chk("t1_ovf", bus.ovf_err, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin wreq = 1'b1; waddr = 4'd5; wdat = 16'hABCD; end
      if (i == 3) begin wreq = 1'b1; waddr = 4'd6; wdat = 16'h5A5A; end
      cyc(1, 1, 0);
      chk("t2_addr", bus.mem_addr, i);
      chk("t2_we", bus.mem_we, 0);
      chk("t2_pvld", bus.pix_valid, (i > 0));
      if (i > 0) chk("t2_pdata", bus.pix_data, f2pix(i - 1));
      if (i == 0 || i == 3) chk("t3_noack_on_tick", bus.wr_ack, 0);
      cyc(0, 1, 0);
      if (i == 0 || i == 3) begin
        chk("t3_ack", bus.wr_ack, 1);
        chk("t3_we", bus.mem_we, 1);
        chk("t3_waddr", bus.mem_addr, waddr);
        chk("t3_wdata", bus.mem_wdata, wdat);
        chk("t3_err", bus.wr_err, 0);
        chk("t5_blank_noack", bus_b.wr_ack, 0);
        wreq = 1'b0;
      end else begin
        chk("t2_idle_ack", bus.wr_ack, 0);
      end
    end
    cyc(0, 1, 0);
    chk("t2_last_pdata", bus.pix_data, 16'h1007);

    // ninth read without a frame start wraps and overflows
    cyc(1, 1, 0);
    chk("t4_addr", bus.mem_addr, 0);
    chk("t4_ovf_pre", bus.ovf_err, 0);
    cyc(0, 1, 0);
    chk("t4_ovf", bus.ovf_err, 1);
    chk("t4_ovf_b", bus_b.ovf_err, 1);
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    chk("t4_ovf_sticky", bus.ovf_err, 1);

    // out-of-range write, then back-to-back in-range write
    wreq = 1'b1; waddr = 4'd8; wdat = 16'h1234;
    cyc(0, 1, 0);
    chk("t5_ack", bus.wr_ack, 1);
    chk("t5_err", bus.wr_err, 1);
    chk("t5_we", bus.mem_we, 0);
    chk("t5_addr", bus.mem_addr, 8);
    chk("t5_b_den_noack", bus_b.wr_ack, 0);
    waddr = 4'd3; wdat = 16'h3333;
    cyc(0, 0, 0);
    chk("t5_b2b_ack", bus.wr_ack, 1);
    chk("t5_b2b_err", bus.wr_err, 0);
    chk("t5_b2b_we", bus.mem_we, 1);
    chk("t5_b_ack", bus_b.wr_ack, 1);
    chk("t5_b_we", bus_b.mem_we, 1);
    wreq = 1'b0;
    cyc(0, 0, 0);
    chk("t5_idle_we", bus.mem_we, 0);
    chk("t5_idle_addr", bus.mem_addr, 3);
    chk("t5_idle_wdata", bus.mem_wdata, 16'h3333);
    chk("t5_ram8", ram[8], 16'h1008);
    chk("t5_ram3", ram[3], 16'h3333);

    // reset mid-line with a request pending
    wreq = 1'b1; waddr = 4'd2; wdat = 16'h7777;
    cyc(1, 1, 0);
    chk("t6_noack_tick", bus.wr_ack, 0);
    rst_d = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_ack", bus.wr_ack, 0);
    chk("t6_we", bus.mem_we, 0);
    chk("t6_addr", bus.mem_addr, 0);
    chk("t6_inframe", bus.in_frame, 0);
    chk("t6_ovf", bus.ovf_err, 0);
    chk("t6_pdata", bus.pix_data, 0);
    cyc(1, 1, 0);
    chk("t6_hold_ack", bus.wr_ack, 0);
    chk("t6_hold_b_ack", bus_b.wr_ack, 0);
    rst_d = 1'b0;
    cyc(1, 1, 0);
    chk("t6_post_ack", bus.wr_ack, 1);
    chk("t6_post_we", bus.mem_we, 1);
    chk("t6_post_addr", bus.mem_addr, 2);
    chk("t6_post_b_ack", bus_b.wr_ack, 1);
    wreq = 1'b0;
    cyc(1, 1, 0);
    chk("t6_noread_we", bus.mem_we, 0);
    chk("t6_noread_addr", bus.mem_addr, 2);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    chk("t6_no_pvld", bus.pix_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    bus.pix_tick = 0;   bus.den = 0;   bus.frame_st = 0;
    bus.wr_req = 0;     bus.wr_addr = '0;   bus.wr_data = '0;
    bus_b.pix_tick = 0; bus_b.den = 0; bus_b.frame_st = 0;
    bus_b.wr_req = 0;   bus_b.wr_addr = '0; bus_b.wr_data = '0;
  end
endmodule
